mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Optional macro MULDIV_ABORT_EN adds an abort input that cancels an in-flight operation.
//
// state  | meaning
// IDLE   | waiting for start; results held
// RUN    | one multiply/divide step per cycle, 32 steps
// FINISH | sign correction, results written, done pulsed on exit
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               divzero_q, divzero_d;
    logic               done_q, done_d;

    logic               abort_act;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] step_val;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_ABORT_EN
    assign abort_act = abort && (state_q != S_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divzero = divzero_q;

    assign a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

    // acc holds {partial product, multiplier} for mult and {remainder, quotient/dividend} for div
    always_comb begin
        mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
        if (!is_div_q) begin
            step_val = {mult_sum, acc_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            step_val = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            step_val = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_q  ? -acc_q : acc_q;
        quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    if (op[1]) begin
                        mcand_d = b_mag;
                        rneg_d  = op[0] & a[WIDTH-1];
                        if (b == '0) begin
                            // divide by zero skips the iterations; hi=a, lo=all ones
                            dz_d    = 1'b1;
                            acc_d   = {a, {WIDTH{1'b1}}};
                            state_d = S_FINISH;
                        end else begin
                            dz_d    = 1'b0;
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            state_d = S_RUN;
                        end
                    end else begin
                        mcand_d = a_mag;
                        rneg_d  = 1'b0;
                        dz_d    = 1'b0;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = step_val;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                divzero_d = dz_q;
                if (dz_q) begin
                    hi_d = acc_q[2*WIDTH-1:WIDTH];
                    lo_d = acc_q[WIDTH-1:0];
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_act) begin
            state_d   = S_IDLE;
            done_d    = 1'b0;
            hi_d      = hi_q;
            lo_d      = lo_q;
            divzero_d = divzero_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences, random ops vs. arithmetic model.
// Abort sequences are included when MULDIV_ABORT_EN is defined.
module tb_mult_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;
`ifdef MULDIV_ABORT_EN
    logic        abort;
`endif

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int exp_done = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
`ifdef MULDIV_ABORT_EN
        .abort   (abort),
`endif
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .divzero (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (resetn && done) done_cnt++;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {divzero, hi, lo} computed with plain integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
            2'b01: begin p = sx * sy; return {1'b0, p}; end
            default: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
                if (o == 2'b10) return {1'b0, x % y, x / y};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Call at posedge+1; returns at posedge+1 of the done cycle (or after timeout).
    task automatic wait_done(input int n0, output int lat, output int bcnt);
        lat  = n0;
        bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        wait_done(1, lat, bcnt);
        exp_done++;
    endtask

    task automatic check_result(input string tag, input logic [1:0] o, input logic [31:0] x,
                                input logic [31:0] y, input int lat, input int bcnt);
        logic [64:0] e;
        int el;
        e  = model(o, x, y);
        el = (o[1] && y == 32'd0) ? 2 : 34;
        check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        check({tag, " divzero"}, 64'(divzero), 64'(e[64]));
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " busy cycles"}, 64'(bcnt), 64'(el - 1));
    endtask

    initial begin
        int lat, bcnt, dc;
        logic [31:0] ph, pl;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        vecs[0] = '{2'b00, 32'd5,        32'd7,        32'd0,        32'd35,       1'b0, 34};
        vecs[1] = '{2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[3] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[4] = '{2'b10, 32'd7,        32'd5,        32'd2,        32'd1,        1'b0, 34};
        vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};
        vecs[6] = '{2'b10, 32'd10,       32'd0,        32'd10,       32'hFFFFFFFF, 1'b1, 2};
        vecs[7] = '{2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 34};
        vecs[8] = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};

        resetn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        check("reset state", {busy, done, divzero, hi, lo}, 67'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // directed table, issued back-to-back (each start lands in the previous done cycle)
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d divzero", i), 64'(divzero), 64'(vecs[i].dz));
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d busy cycles", i), 64'(bcnt), 64'(vecs[i].lat - 1));
        end
        tick();
        check("done single pulse", 64'(done), 64'd0);

        // start ignored while busy; results hold until completion
        ph = hi; pl = lo;
        op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        check("hold during run", {hi, lo}, {ph, pl});
        wait_done(5, lat, bcnt);
        exp_done++;
        check("ignored start lo", 64'(lo), 64'd35);
        check("ignored start hi", 64'(hi), 64'd0);
        check("ignored start latency", 64'(lat), 64'd34);
        repeat (3) tick();
        check("hold when idle", {hi, lo, divzero}, {32'd0, 32'd35, 1'b0});

        // reset mid-operation
        op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        dc = done_cnt;
        #2 resetn = 1'b0;
        #1;
        check("async reset clears", {busy, done, divzero, hi, lo}, 67'd0);
        tick();
        resetn = 1'b1;
        repeat (40) tick();
        check("no done after reset", 64'(done_cnt), 64'(dc));
        run_op(2'b01, 32'hFFFFFFFD, 32'd7, lat, bcnt);
        check_result("post-reset", 2'b01, 32'hFFFFFFFD, 32'd7, lat, bcnt);

`ifdef MULDIV_ABORT_EN
        ph = hi; pl = lo;
        op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        dc = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort to idle", 64'(busy), 64'd0);
        check("abort keeps results", {hi, lo, divzero}, {ph, pl, 1'b0});
        repeat (40) tick();
        check("abort no done", 64'(done_cnt), 64'(dc));
        op = 2'b10; a = 32'd10; b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort in finish", {busy, done, divzero, hi, lo}, {1'b0, 1'b0, 1'b0, ph, pl});
        tick();
        abort = 1'b1;
        run_op(2'b00, 32'd2, 32'd3, lat, bcnt);
        abort = 1'b0;
        check_result("abort idle ignored", 2'b00, 32'd2, 32'd3, lat, bcnt);
`endif

        // randomized operations against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            logic [31:0] specials [5];
            specials = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
            ro = 2'($urandom_range(0, 3));
            rx = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 9))
                0:       ry = 32'd0;
                1, 2:    ry = specials[$urandom_range(0, 4)];
                3:       ry = 32'($urandom_range(1, 16));
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                ph = hi; pl = lo;
                repeat ($urandom_range(1, 3)) tick();
                check($sformatf("rnd%0d idle hold", i), {hi, lo}, {ph, pl});
            end
            run_op(ro, rx, ry, lat, bcnt);
            check_result($sformatf("rnd%0d op%0d %h %h", i, ro, rx, ry), ro, rx, ry, lat, bcnt);
        end

        tick();
        check("total done pulses", 64'(done_cnt), 64'(exp_done));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
